bus_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one 32-bit datapath bus among four requesters.

---
 rtl/bus_rr_arbiter_if.sv | 24 ++
 rtl/bus_rr_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_rr_arbiter_if.sv
// Bus bundle shared by the four requesters and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface bus_rr_arbiter_if;
    logic [3:0]  req;
    logic [31:0] input0;
    logic [31:0] input1;
    logic [31:0] input2;
    logic [31:0] input3;
    logic [3:0]  grant;
    logic [1:0]  sel;
    logic        busy;
    logic [31:0] bus_out;
    logic        timeout;

    modport master (
        output req, input0, input1, input2, input3,
        input  grant, sel, busy, bus_out, timeout
    );

    modport slave (
        input  req, input0, input1, input2, input3,
        output grant, sel, busy, bus_out, timeout
    );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Four-way round-robin arbiter for the shared 32-bit bus, with registered one-hot grant.
// Define ARB_WATCHDOG_EN to force release of an owner after HOLD_MAX consecutive grant cycles.
//
// state | meaning
// IDLE  | no owner; pick next eligible requester after ptr
// GRANT | bus owned by requester sel until it drops req (or watchdog fires)
module bus_rr_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input logic           clk,
    input logic           reset,
    bus_rr_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    if (HOLD_MAX < 2) begin : g_hold_max_check
        $error("bus_rr_arbiter: HOLD_MAX must be >= 2");
    end

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  ptr_q;
    logic [1:0]  ptr_d;
    logic [1:0]  sel_q;
    logic [1:0]  sel_d;
    logic [3:0]  grant_q;
    logic [3:0]  grant_d;
    logic        busy_q;
    logic        busy_d;
    logic [3:0]  eligible;
    logic [1:0]  winner;
    logic [1:0]  cand;
    logic        found;
    logic        owner_req;
    logic        limit_hit;
    logic        release_now;

`ifdef ARB_WATCHDOG_EN
    localparam int CW = $clog2(HOLD_MAX);

    logic [CW-1:0] hold_cnt_q;
    logic [CW-1:0] hold_cnt_d;
    logic [3:0]    mask_q;
    logic [3:0]    mask_d;
    logic          timeout_q;
    logic          timeout_d;

    assign limit_hit = (hold_cnt_q == CW'(HOLD_MAX - 1));
    assign eligible  = bus.req & ~mask_q;
`else
    assign limit_hit = 1'b0;
    assign eligible  = bus.req;
`endif

    assign owner_req   = bus.req[sel_q];
    assign release_now = !owner_req || limit_hit;

    // Scan ptr+1, ptr+2, ptr+3, ptr; the first eligible index wins.
    always_comb begin
        winner = ptr_q;
        found  = 1'b0;
        cand   = ptr_q;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!found && eligible[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd3;
            sel_q   <= 2'd0;
            grant_q <= 4'b0000;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = GRANT;
            GRANT:   if (release_now) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = 4'b0001 << winner;
                    sel_d   = winner;
                    ptr_d   = winner;
                    busy_d  = 1'b1;
                end
            end
            GRANT: begin
                if (release_now) begin
                    grant_d = 4'b0000;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                grant_d = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

`ifdef ARB_WATCHDOG_EN
    // A release on the limit edge only counts as a timeout if the owner still wants the bus.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE:    if (found) hold_cnt_d = '0;
            GRANT: begin
                if (release_now) begin
                    timeout_d = owner_req && limit_hit;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: hold_cnt_d = '0;
        endcase
        mask_d = (mask_q & bus.req) | (timeout_d ? grant_q : 4'b0000);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt_q <= '0;
            mask_q     <= 4'b0000;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            mask_q     <= mask_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.grant = grant_q;
    assign bus.sel   = sel_q;
    assign bus.busy  = busy_q;

    always_comb begin
        bus.bus_out = 32'h0;
        if (busy_q) begin
            case (sel_q)
                2'd0:    bus.bus_out = bus.input0;
                2'd1:    bus.bus_out = bus.input1;
                2'd2:    bus.bus_out = bus.input2;
                default: bus.bus_out = bus.input3;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench for bus_rr_arbiter: stimulus queues expected grants, a negedge monitor checks them.
// Build with ARB_WATCHDOG_EN to exercise the forced-release path (HOLD_MAX=4).
module tb_bus_rr_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

`ifdef ARB_WATCHDOG_EN
    localparam int HM = 4;
`else
    localparam int HM = 16;
`endif

    bus_rr_arbiter_if bif();

    bus_rr_arbiter #(.HOLD_MAX(HM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    typedef struct {
        logic [3:0]  grant;
        logic [1:0]  sel;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [31:0] din [4];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_mis = 0;
    bit          mon_en = 1'b0;
    logic [3:0]  prev_grant = 4'b0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input int owner, input int at);
        exp_t e;
        e.grant = 4'b0001 << owner;
        e.sel   = 2'(owner);
        e.data  = din[owner];
        e.cyc   = at;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        bif.req = 4'b0000;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bif.grant != 4'b0000 && prev_grant == 4'b0000) begin
                if (sb.size() == 0) begin
                    chk("unexpected_grant", 32'(bif.grant), 32'h0);
                    cur = '{4'b0000, 2'd0, 32'h0, 0};
                end else begin
                    cur = sb.pop_front();
                    chk("grant_cycle", 32'(cyc), 32'(cur.cyc));
                    chk("grant_sel", 32'(bif.sel), 32'(cur.sel));
                end
            end
            if (bif.grant != 4'b0000) begin
                chk("grant_value", 32'(bif.grant), 32'(cur.grant));
                chk("busy_high", 32'(bif.busy), 32'h1);
                chk("bus_out_owner", bif.bus_out, cur.data);
            end else begin
                chk("busy_low", 32'(bif.busy), 32'h0);
                chk("bus_out_idle", bif.bus_out, 32'h0);
            end
            prev_grant = bif.grant;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int owner;
        din[0] = 32'h1111_0000;
        din[1] = 32'h2222_0001;
        din[2] = 32'h3333_0002;
        din[3] = 32'h4444_0003;
        bif.req    = 4'b0000;
        bif.input0 = din[0];
        bif.input1 = din[1];
        bif.input2 = din[2];
        bif.input3 = din[3];
        reset = 1'b1;
        step(2);

        // reset state
        chk("rst_grant", 32'(bif.grant), 32'h0);
        chk("rst_sel", 32'(bif.sel), 32'h0);
        chk("rst_busy", 32'(bif.busy), 32'h0);
        chk("rst_timeout", 32'(bif.timeout), 32'h0);
        chk("rst_bus_out", bif.bus_out, 32'h0);
        reset = 1'b0;
        step(1);
        mon_en = 1'b1;

        // 1: single request, one-cycle latency
        bif.req = 4'b0001;
        expect_grant(0, cyc + 1);
        step(2);
        bif.req = 4'b0000;
        step(2);

        // 2: all requesting, rotation 0,1,2,3,0 with one idle cycle between
        do_reset();
        base = cyc;
        bif.req = 4'b1111;
        for (int k = 0; k < 5; k++) expect_grant(k % 4, base + 1 + 5 * k);
        step(1);
        for (int k = 0; k < 5; k++) begin
            owner = k % 4;
            step(3);
            bif.req[owner] = 1'b0;
            if (k == 4) bif.req = 4'b0000;
            step(1);
            chk("t2_no_timeout", 32'(bif.timeout), 32'h0);
            if (k < 4) bif.req[owner] = 1'b1;
            step(1);
        end
        step(1);

        // 3: no preemption by a late request
        do_reset();
        bif.req = 4'b0100;
        expect_grant(2, cyc + 1);
        step(2);
        bif.req[0] = 1'b1;
        step(2);
        chk("t3_no_preempt", 32'(bif.grant), 32'h4);
        bif.req[2] = 1'b0;
        expect_grant(0, cyc + 2);
        step(1);
        chk("t3_idle_gap", 32'(bif.grant), 32'h0);
        step(3);
        bif.req = 4'b0000;
        step(2);

        // 4: async reset mid-grant, then ptr restarts at 3
        do_reset();
        bif.req = 4'b0010;
        expect_grant(1, cyc + 1);
        step(2);
        #3;
        bif.req = 4'b0000;
        reset = 1'b1;
        #1;
        chk("t4_async_grant", 32'(bif.grant), 32'h0);
        chk("t4_async_busy", 32'(bif.busy), 32'h0);
        chk("t4_async_bus_out", bif.bus_out, 32'h0);
        #2;
        reset = 1'b0;
        step(1);
        bif.req = 4'b1111;
        expect_grant(0, cyc + 1);
        step(3);
        bif.req = 4'b0000;
        step(2);

`ifdef ARB_WATCHDOG_EN
        // 5: forced release after HOLD_MAX cycles, owner masked until it drops
        do_reset();
        base = cyc;
        bif.req = 4'b1010;
        expect_grant(1, base + 1);
        step(4);
        chk("t5_hold_last", 32'(bif.grant), 32'h2);
        chk("t5_timeout_low", 32'(bif.timeout), 32'h0);
        step(1);
        chk("t5_forced_release", 32'(bif.grant), 32'h0);
        chk("t5_timeout_pulse", 32'(bif.timeout), 32'h1);
        expect_grant(3, cyc + 1);
        step(1);
        chk("t5_timeout_one_cycle", 32'(bif.timeout), 32'h0);
        step(1);
        bif.req[3] = 1'b0;
        step(3);
        chk("t5_masked_idle", 32'(bif.grant), 32'h0);
        chk("t5_voluntary_no_timeout", 32'(bif.timeout), 32'h0);
        bif.req[1] = 1'b0;
        step(1);
        bif.req[1] = 1'b1;
        expect_grant(1, cyc + 1);
        step(2);
        bif.req = 4'b0000;
        step(2);
`else
        // 6: without the watchdog the owner may hold indefinitely
        do_reset();
        bif.req = 4'b1010;
        expect_grant(1, cyc + 1);
        step(1);
        for (int i = 0; i < 100; i++) begin
            chk("t6_hold", 32'(bif.grant), 32'h2);
            chk("t6_timeout", 32'(bif.timeout), 32'h0);
            step(1);
        end
        bif.req[1] = 1'b0;
        expect_grant(3, cyc + 2);
        step(3);
        bif.req = 4'b0000;
        step(2);
`endif

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
